// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: lock/request inputs and staged reset outputs of the reset sequencer
interface reset_sequencer_if;
    logic       locked_in;
    logic       sw_reset_req;
    logic       rst_n_adc;
    logic       rst_n_ddc;
    logic       rst_n_fft;
    logic       rst_n_eth;
    logic       sys_ready;
    logic [2:0] seq_state;
    logic [7:0] lol_count;
    logic       lol_sticky;
    modport master (
        output locked_in, sw_reset_req,
        input  rst_n_adc, rst_n_ddc, rst_n_fft, rst_n_eth, sys_ready, seq_state, lol_count, lol_sticky
    );
    modport slave (
        input  locked_in, sw_reset_req,
        output rst_n_adc, rst_n_ddc, rst_n_fft, rst_n_eth, sys_ready, seq_state, lol_count, lol_sticky
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: qualifies PLL lock and releases ADC->DDC->FFT->ETH resets in order; RESET_SEQ_LOL_CNT_EN enables loss-of-lock counting
module reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int LOL_FILTER_CYCLES  = 4
) (
    input logic clk_100m_in,
    input logic rst,
    reset_sequencer_if.slave bus
);
    localparam int CW = $clog2(LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES) + 1;
    localparam int FW = $clog2(LOL_FILTER_CYCLES) + 1;
    typedef enum logic [2:0] {WAIT_LOCK, REL_ADC, REL_DDC, REL_FFT, REL_ETH, RUN, LOST} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] filt, filt_n;
    logic sync1, locked_s, lol_evt;
    // two-flop synchroniser; the only consumer of the asynchronous lock input
    always_ff @(posedge clk_100m_in or posedge rst)
        if (rst) {locked_s, sync1} <= 2'b00;
        else     {locked_s, sync1} <= {sync1, bus.locked_in};
    // next state: cnt is the lock-stable count in WAIT_LOCK and the gap/hold timer elsewhere
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        filt_n  = '0;
        lol_evt = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (locked_s && !bus.sw_reset_req) begin
                    if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) state_n = REL_ADC;
                    else cnt_n = cnt + 1'b1;
                end
            end
            LOST: begin
                if (!bus.sw_reset_req) begin
                    if (cnt == CW'(STAGE_GAP_CYCLES - 1)) state_n = WAIT_LOCK;
                    else cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                filt_n  = locked_s ? '0 : filt + 1'b1;
                lol_evt = !locked_s && filt == FW'(LOL_FILTER_CYCLES - 1);
                if (lol_evt || bus.sw_reset_req) begin
                    state_n = LOST;
                    filt_n  = '0;
                end else if (state != RUN) begin
                    if (cnt == CW'(STAGE_GAP_CYCLES - 1)) state_n = state_t'(state + 3'd1);
                    else cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end
    // state register; reset outputs decode the next state so each release lands on the transition edge
    always_ff @(posedge clk_100m_in or posedge rst)
        if (rst) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            filt          <= '0;
            bus.rst_n_adc <= 1'b0;
            bus.rst_n_ddc <= 1'b0;
            bus.rst_n_fft <= 1'b0;
            bus.rst_n_eth <= 1'b0;
            bus.sys_ready <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            filt          <= filt_n;
            bus.rst_n_adc <= state_n inside {REL_ADC, REL_DDC, REL_FFT, REL_ETH, RUN};
            bus.rst_n_ddc <= state_n inside {REL_DDC, REL_FFT, REL_ETH, RUN};
            bus.rst_n_fft <= state_n inside {REL_FFT, REL_ETH, RUN};
            bus.rst_n_eth <= state_n inside {REL_ETH, RUN};
            bus.sys_ready <= state_n == RUN;
        end
    assign bus.seq_state = state;
`ifdef RESET_SEQ_LOL_CNT_EN
    // saturating count of filtered lock losses; software requests are not counted
    always_ff @(posedge clk_100m_in or posedge rst)
        if (rst) begin
            bus.lol_count  <= '0;
            bus.lol_sticky <= 1'b0;
        end else if (lol_evt) begin
            bus.lol_count  <= bus.lol_count == 8'hff ? 8'hff : bus.lol_count + 8'd1;
            bus.lol_sticky <= 1'b1;
        end
`else
    assign bus.lol_count  = '0;
    assign bus.lol_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench; expected state transitions are queued by stimulus and checked by a monitor
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    reset_sequencer_if b1();
    reset_sequencer_if b2();
    reset_sequencer u1 (.clk_100m_in(clk), .rst(rst), .bus(b1));
    reset_sequencer #(.LOCK_STABLE_CYCLES(4), .STAGE_GAP_CYCLES(2), .LOL_FILTER_CYCLES(4))
        u2 (.clk_100m_in(clk), .rst(rst), .bus(b2));
`ifdef RESET_SEQ_LOL_CNT_EN
    localparam bit LOLEN = 1'b1;
`else
    localparam bit LOLEN = 1'b0;
`endif
    typedef struct {
        int         e;
        logic [2:0] st;
        logic [3:0] rn;
        logic       rdy;
        logic [7:0] lc;
        logic       sk;
    } exp_t;
    exp_t sb[$];
    exp_t mx;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int c;
    logic [7:0] exp_lol = 8'd0;
    logic exp_sk = 1'b0;
    logic [2:0] prev_st = 3'd0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", n, got, want, cyc);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input int e, input int st, input logic [3:0] rn, input logic rdy);
        exp_t x;
        x.e = e; x.st = 3'(st); x.rn = rn; x.rdy = rdy; x.lc = exp_lol; x.sk = exp_sk;
        sb.push_back(x);
    endtask
    task automatic push_seq(input int base, input int n);
        for (int i = 0; i < n; i++)
            push(base + 16 * i, i + 1, i >= 3 ? 4'hf : 4'((1 << (i + 1)) - 1), i == 4);
    endtask
    task automatic lost_event();
        if (LOLEN) begin
            exp_lol = exp_lol == 8'hff ? 8'hff : exp_lol + 8'd1;
            exp_sk  = 1'b1;
        end
    endtask
    task automatic wait_state(input bit d2, input logic [2:0] st, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            tick();
            if ((d2 ? b2.seq_state : b1.seq_state) == st) break;
        end
        if (i == bound) begin
            total++;
            bad++;
            $display("FAIL wait_state dut%0d: state %0d not reached in %0d cycles", d2 ? 2 : 1, st, bound);
        end
    endtask
    // monitor: every state change of dut1 must match the next queued expectation
    always @(negedge clk) begin
        chk("release_order",
            {63'd0, (!b1.rst_n_eth || b1.rst_n_fft) && (!b1.rst_n_fft || b1.rst_n_ddc) &&
                    (!b1.rst_n_ddc || b1.rst_n_adc) && (!b1.sys_ready || b1.rst_n_eth)}, 64'd1);
        if (b1.seq_state !== prev_st) begin
            prev_st = b1.seq_state;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_transition: got state %0d at edge %0d want none", b1.seq_state, cyc);
            end else begin
                mx = sb.pop_front();
                chk("transition",
                    {15'd0, 32'(cyc), b1.seq_state, b1.rst_n_eth, b1.rst_n_fft, b1.rst_n_ddc, b1.rst_n_adc,
                     b1.sys_ready, b1.lol_count, b1.lol_sticky},
                    {15'd0, 32'(mx.e), mx.st, mx.rn, mx.rdy, mx.lc, mx.sk});
            end
        end
    end
    initial begin
        b1.locked_in = 1'b0; b1.sw_reset_req = 1'b0;
        b2.locked_in = 1'b0; b2.sw_reset_req = 1'b0;
        repeat (5) tick();
        chk("reset_outputs",
            {b1.seq_state, b1.rst_n_adc, b1.rst_n_ddc, b1.rst_n_fft, b1.rst_n_eth, b1.sys_ready,
             b1.lol_count, b1.lol_sticky}, 64'd0);
        // power-up sequence
        c = cyc;
        push_seq(c + 1026, 5);
        rst = 1'b0;
        b1.locked_in = 1'b1;
        wait_state(1'b0, 3'd5, 2000);
        repeat (4) tick();
        // 3-cycle glitch is filtered out
        b1.locked_in = 1'b0;
        repeat (3) tick();
        b1.locked_in = 1'b1;
        repeat (10) tick();
        chk("glitch_ignored", {60'd0, b1.seq_state, b1.sys_ready}, {60'd0, 3'd5, 1'b1});
        // 4-cycle loss goes to LOST, then resequence up to REL_FFT
        c = cyc;
        lost_event();
        push(c + 6, 6, 4'h0, 1'b0);
        push(c + 22, 0, 4'h0, 1'b0);
        push_seq(c + 22 + 1024, 3);
        b1.locked_in = 1'b0;
        repeat (4) tick();
        b1.locked_in = 1'b1;
        wait_state(1'b0, 3'd3, 1200);
        // software request in REL_FFT: immediate LOST, not counted
        c = cyc;
        push(c + 1, 6, 4'h0, 1'b0);
        push(c + 17, 0, 4'h0, 1'b0);
        push_seq(c + 1041, 5);
        b1.sw_reset_req = 1'b1;
        tick();
        b1.sw_reset_req = 1'b0;
        wait_state(1'b0, 3'd5, 1200);
        repeat (3) tick();
        // software request in RUN, then async reset during REL_DDC
        c = cyc;
        push(c + 1, 6, 4'h0, 1'b0);
        push(c + 17, 0, 4'h0, 1'b0);
        push_seq(c + 1041, 2);
        b1.sw_reset_req = 1'b1;
        tick();
        b1.sw_reset_req = 1'b0;
        wait_state(1'b0, 3'd2, 1200);
        repeat (3) tick();
        exp_lol = 8'd0;
        exp_sk  = 1'b0;
        push(cyc, 0, 4'h0, 1'b0);
        rst = 1'b1;
        b1.locked_in = 1'b0;
        #1;
        chk("async_reset_outputs",
            {b1.seq_state, b1.rst_n_adc, b1.rst_n_ddc, b1.rst_n_fft, b1.rst_n_eth, b1.sys_ready,
             b1.lol_count, b1.lol_sticky}, 64'd0);
        repeat (3) tick();
        // flaky lock after reset: the 1-cycle drop restarts the stable count
        rst = 1'b0;
        c = cyc;
        push_seq(c + 502 + 1025, 5);
        b1.locked_in = 1'b1;
        repeat (500) tick();
        b1.locked_in = 1'b0;
        tick();
        b1.locked_in = 1'b1;
        wait_state(1'b0, 3'd5, 1200);
        // small instance: 300 filtered loss events
        for (int i = 0; i < 300; i++) begin
            b2.locked_in = 1'b1;
            wait_state(1'b1, 3'd1, 100);
            b2.locked_in = 1'b0;
            wait_state(1'b1, 3'd6, 100);
            if (i == 0)
                chk("lol_first", {55'd0, b2.lol_count, b2.lol_sticky}, LOLEN ? 64'h3 : 64'h0);
            b2.locked_in = 1'b1;
            wait_state(1'b1, 3'd0, 100);
        end
        chk("lol_saturated", {55'd0, b2.lol_count, b2.lol_sticky}, LOLEN ? {55'd0, 8'hff, 1'b1} : 64'h0);
        repeat (5) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
